// File: rtl/ex_div_pkg.sv
// Shared definitions for the execute-stage divider: state encodings,
// result width and the divide opcodes that select this unit.
package ex_div_pkg;

    localparam int unsigned DIV_DATA_W   = 32;
    localparam int unsigned DIV_CNT_W    = 6;
    localparam int unsigned DIV_RESULT_W = 2 * DIV_DATA_W;

    // Execute-stage opcodes routed to the divider
    localparam logic [7:0] EXE_OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] EXE_OP_DIVU = 8'b0001_1011;

    typedef enum logic [1:0] {
        DIV_ST_IDLE   = 2'b00,
        DIV_ST_BYZERO = 2'b01,
        DIV_ST_ON     = 2'b10,
        DIV_ST_END    = 2'b11
    } div_state_e;

endpackage

// File: rtl/ex_div_step.sv
// One radix-2 restoring iteration: trial-subtract the divisor from the
// shifted partial remainder and keep the difference only if it is non-negative.
module ex_div_step
    import ex_div_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_DATA_W
) (
    input  logic [DATA_W:0]   i_partial,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W-1:0] o_rem,
    output logic              o_qbit
);

    logic [DATA_W:0] w_divisor_ext;
    logic            w_ge;

    assign w_divisor_ext = {1'b0, i_divisor};
    assign w_ge          = (i_partial >= w_divisor_ext);

    // Restore (keep the shifted value) when the trial subtraction would go negative
    always_comb begin
        o_qbit = w_ge;
        o_rem  = w_ge ? DATA_W'(i_partial - w_divisor_ext) : i_partial[DATA_W-1:0];
    end

endmodule

// File: rtl/ex_div.sv
// Multi-cycle restoring divider for DIV/DIVU with stall, annul and
// divide-by-zero handling. Result is {remainder, quotient} for HI/LO.
// Optional: define EX_DIV_EARLY_OUT_EN to finish immediately when
// |dividend| < |divisor|.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_DATA_W,
    parameter int unsigned CNT_W  = DIV_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  div_i_start,
    input  logic                  div_i_signed,
    input  logic [DATA_W-1:0]     div_i_opdata1,
    input  logic [DATA_W-1:0]     div_i_opdata2,
    input  logic                  div_i_annul,
    output logic [2*DATA_W-1:0]   div_o_result,
    output logic                  div_o_ready,
    output logic                  div_o_stallreq
);

    div_state_e          r_state;
    div_state_e          w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_dvd;
    logic [DATA_W-1:0]   r_dvs;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [2*DATA_W-1:0] r_result;

    logic [DATA_W-1:0]   w_abs_dvd;
    logic [DATA_W-1:0]   w_abs_dvs;
    logic [DATA_W-1:0]   w_step_rem;
    logic                w_step_q;
    logic [DATA_W-1:0]   w_q_raw;
    logic [DATA_W-1:0]   w_q_final;
    logic [DATA_W-1:0]   w_r_final;
    logic                w_dvs_zero;
    logic                w_last;
    logic                w_early;
    logic                w_go;

    // Magnitudes; 0x80000000 negates to itself and is read as 2^31
    assign w_abs_dvd  = (div_i_signed && div_i_opdata1[DATA_W-1]) ? -div_i_opdata1 : div_i_opdata1;
    assign w_abs_dvs  = (div_i_signed && div_i_opdata2[DATA_W-1]) ? -div_i_opdata2 : div_i_opdata2;
    assign w_dvs_zero = (div_i_opdata2 == '0);
    assign w_go       = div_i_start && !div_i_annul;
    assign w_last     = (r_cnt == CNT_W'(DATA_W - 1));

`ifdef EX_DIV_EARLY_OUT_EN
    assign w_early = (w_abs_dvd < w_abs_dvs);
`else
    assign w_early = 1'b0;
`endif

    ex_div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .i_partial (({r_rem, r_dvd[DATA_W-1]})),
        .i_divisor (r_dvs),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_q)
    );

    assign w_q_raw   = {r_dvd[DATA_W-2:0], w_step_q};
    assign w_q_final = r_neg_q ? -w_q_raw : w_q_raw;
    assign w_r_final = r_neg_r ? -w_step_rem : w_step_rem;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DIV_ST_IDLE: begin
                if (w_go) begin
                    if (w_dvs_zero)   w_next_state = DIV_ST_BYZERO;
                    else if (w_early) w_next_state = DIV_ST_END;
                    else              w_next_state = DIV_ST_ON;
                end
            end
            DIV_ST_BYZERO: w_next_state = div_i_annul ? DIV_ST_IDLE : DIV_ST_END;
            DIV_ST_ON: begin
                if (div_i_annul) w_next_state = DIV_ST_IDLE;
                else if (w_last) w_next_state = DIV_ST_END;
            end
            DIV_ST_END: begin
                if (!div_i_start || div_i_annul) w_next_state = DIV_ST_IDLE;
            end
            default: w_next_state = DIV_ST_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                DIV_ST_IDLE: begin
                    if (w_go && !w_dvs_zero) begin
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_dvd   <= w_abs_dvd;
                        r_dvs   <= w_abs_dvs;
                        r_neg_q <= div_i_signed && (div_i_opdata1[DATA_W-1] ^ div_i_opdata2[DATA_W-1]);
                        r_neg_r <= div_i_signed && div_i_opdata1[DATA_W-1];
                        if (w_early) begin
                            r_result <= {div_i_opdata1, DATA_W'(0)};
                        end
                    end
                end
                DIV_ST_BYZERO: begin
                    if (!div_i_annul) r_result <= '0;
                end
                DIV_ST_ON: begin
                    if (!div_i_annul) begin
                        r_rem <= w_step_rem;
                        r_dvd <= w_q_raw;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) r_result <= {w_r_final, w_q_final};
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode; stall request follows the live start/annul inputs
    always_comb begin
        div_o_ready    = (r_state == DIV_ST_END);
        div_o_stallreq = div_i_start && (r_state != DIV_ST_END) && !div_i_annul;
    end

    assign div_o_result = r_result;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: arithmetic reference model plus
// per-cycle comparison of ready, stall request and result.
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sg;
    logic        annul;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [63:0] result;
    logic        ready;
    logic        stall;

    int checks = 0;
    int errors = 0;

    logic        m_chk    = 1'b0;
    logic        m_ready  = 1'b0;
    logic        m_stall  = 1'b0;
    logic [63:0] m_result = '0;

    always #5 clk = ~clk;

    ex_div dut (
        .clk            (clk),
        .rst            (rst),
        .div_i_start    (start),
        .div_i_signed   (sg),
        .div_i_opdata1  (op1),
        .div_i_opdata2  (op2),
        .div_i_annul    (annul),
        .div_o_result   (result),
        .div_o_ready    (ready),
        .div_o_stallreq (stall)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Truncating division on magnitudes, then sign correction
    function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] ma, mb, q, r;
        logic        na, nb;
        if (b == 32'd0) return 64'd0;
        na = s && a[31];
        nb = s && b[31];
        ma = na ? -a : a;
        mb = nb ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (na ^ nb) q = -q;
        if (na)      r = -r;
        return {r, q};
    endfunction

    // Cycles from first start cycle to the first ready cycle
    function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] ma, mb;
        if (b == 32'd0) return 2;
        ma = (s && a[31]) ? -a : a;
        mb = (s && b[31]) ? -b : b;
`ifdef EX_DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        if (ma == mb) return 33;
        return 33;
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_chk) begin
            check("ready", 64'(ready), 64'(m_ready));
            check("stallreq", 64'(stall), 64'(m_stall));
            if (m_ready) check("result", result, m_result);
        end
    end

    // One divide: hold start `hold` cycles past ready, then release
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int hold, input logic [63:0] lit);
        int lat;
        lat = model_lat(a, b, s);
        @(posedge clk); #1;
        op1 = a; op2 = b; sg = s; start = 1'b1; annul = 1'b0;
        m_result = model_div(a, b, s);
        m_ready  = 1'b0;
        m_stall  = 1'b1;
        for (int k = 1; k <= lat + hold; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin
                op1 = ~a; op2 = b + 32'd1; sg = ~s;
            end
            m_ready = (k >= lat);
            m_stall = !m_ready;
            if (k == lat) begin
                @(negedge clk);
                check("lit_result", result, lit);
            end
        end
        @(posedge clk); #1;
        start = 1'b0; m_ready = 1'b1; m_stall = 1'b0;
        @(posedge clk); #1;
        m_ready = 1'b0; m_stall = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; sg = 1'b0; annul = 1'b0; op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_result", result, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_chk = 1'b1;

        run_div(32'd100, 32'd7, 1'b0, 0, 64'h00000002_0000000E);
        run_div(32'hFFFFFFF9, 32'd2, 1'b1, 0, 64'hFFFFFFFF_FFFFFFFD);
        run_div(32'd7, 32'hFFFFFFFE, 1'b1, 0, 64'h00000001_FFFFFFFD);
        run_div(32'd5, 32'd0, 1'b0, 0, 64'h0);
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 64'h00000000_80000000);
        run_div(32'd100, 32'd7, 1'b0, 3, 64'h00000002_0000000E);
        run_div(32'd3, 32'd10, 1'b0, 0, 64'h00000003_00000000);
        run_div(32'hFFFFFFFD, 32'd10, 1'b1, 0, 64'hFFFFFFFD_00000000);
        run_div(32'hFFFFFFFF, 32'd1, 1'b0, 0, 64'h00000000_FFFFFFFF);
        run_div(32'hFFFFFFF9, 32'd2, 1'b0, 0, 64'h00000001_7FFFFFFC);

        // Annul at iteration 10: no ready, then a clean restart
        @(posedge clk); #1;
        op1 = 32'd1000; op2 = 32'd3; sg = 1'b0; start = 1'b1;
        m_ready = 1'b0; m_stall = 1'b1;
        repeat (9) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        annul = 1'b1; m_stall = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        run_div(32'd81, 32'd9, 1'b0, 0, 64'h00000000_00000009);

        // Reset in the middle of an iteration run
        @(posedge clk); #1;
        op1 = 32'd50; op2 = 32'd5; sg = 1'b0; start = 1'b1;
        m_ready = 1'b0; m_stall = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; start = 1'b0; m_stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_result", result, 64'd0);
        check("midrst_ready", 64'(ready), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        run_div(32'd81, 32'd9, 1'b0, 0, 64'h00000000_00000009);

        @(posedge clk); #1;
        m_chk = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
